// File: rtl/updown_count_sequencer.sv
// rtl/updown_count_sequencer.sv - up/down counter sequencer with wrap/bounce bounds and pass limit
module updown_count_sequencer #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [WIDTH-1:0]  cfg_lo,
    input  logic [WIDTH-1:0]  cfg_hi,
    input  logic              cfg_dir,
    input  logic              cfg_bounce,
    input  logic [PASS_W-1:0] cfg_passes,
    output logic [WIDTH-1:0]  count,
    output logic              m,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic              cfg_err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  lo_q, hi_q, lo_nx, hi_nx, count_nx;
    logic [PASS_W-1:0] passes_q, passes_nx, pass_q, pass_nx, pass_inc;
    logic              bounce_q, bounce_nx;
    logic              m_nx, busy_nx, done_nx, wrap_nx, cfg_err_nx;
    logic              hit, final_hit;

    assign pass_inc  = pass_q + PASS_W'(1);
    assign hit       = (m && (count == hi_q)) || (!m && (count == lo_q));
    assign final_hit = hit && (passes_q != '0) && (pass_inc == passes_q);

    always_comb begin
        state_nx   = state;
        lo_nx      = lo_q;
        hi_nx      = hi_q;
        bounce_nx  = bounce_q;
        passes_nx  = passes_q;
        pass_nx    = pass_q;
        count_nx   = count;
        m_nx       = m;
        busy_nx    = busy;
        done_nx    = 1'b0;
        wrap_nx    = 1'b0;
        cfg_err_nx = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_lo <= cfg_hi) begin
                        lo_nx     = cfg_lo;
                        hi_nx     = cfg_hi;
                        bounce_nx = cfg_bounce;
                        passes_nx = cfg_passes;
                        m_nx      = cfg_dir;
                        pass_nx   = '0;
                        busy_nx   = 1'b1;
                        state_nx  = LOAD;
                    end else begin
                        cfg_err_nx = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (stop) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    count_nx = m ? lo_q : hi_q;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else if (!pause) begin
                    if (!hit) begin
                        count_nx = m ? count + WIDTH'(1) : count - WIDTH'(1);
                    end else if (final_hit) begin
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                        state_nx = IDLE;
                    end else begin
                        // pass only matters against a nonzero limit; saturate for run-forever
                        pass_nx = (pass_q == '1) ? pass_q : pass_inc;
                        wrap_nx = 1'b1;
                        if (!bounce_q) begin
                            count_nx = m ? lo_q : hi_q;
                        end else begin
                            m_nx = !m;
                            if (lo_q != hi_q)
                                count_nx = m ? count - WIDTH'(1) : count + WIDTH'(1);
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            bounce_q <= 1'b0;
            passes_q <= '0;
            pass_q   <= '0;
            count    <= '0;
            m        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wrap     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            lo_q     <= lo_nx;
            hi_q     <= hi_nx;
            bounce_q <= bounce_nx;
            passes_q <= passes_nx;
            pass_q   <= pass_nx;
            count    <= count_nx;
            m        <= m_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            wrap     <= wrap_nx;
            cfg_err  <= cfg_err_nx;
        end
    end

endmodule

// File: tb/tb_updown_count_sequencer.sv
// tb/tb_updown_count_sequencer.sv - directed self-checking bench for updown_count_sequencer
module tb_updown_count_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause;
    logic [3:0] cfg_lo, cfg_hi;
    logic       cfg_dir, cfg_bounce;
    logic [7:0] cfg_passes;
    logic [3:0] count;
    logic       m, busy, done, wrap, cfg_err;

    int checks   = 0;
    int failures = 0;

    updown_count_sequencer #(.WIDTH(4), .PASS_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_dir(cfg_dir), .cfg_bounce(cfg_bounce),
        .cfg_passes(cfg_passes), .count(count), .m(m), .busy(busy), .done(done),
        .wrap(wrap), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [3:0] lo, input logic [3:0] hi, input logic dir,
                         input logic bnc, input logic [7:0] passes);
        cfg_lo = lo; cfg_hi = hi; cfg_dir = dir; cfg_bounce = bnc; cfg_passes = passes;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        setup(4'd0, 4'd15, 1'b1, 1'b0, 8'd0);
        step(); step();
        rst = 1'b0;
        checks++;
        if ({count, m, busy, done, wrap, cfg_err} !== 9'b0) begin
            failures++;
            $display("FAIL reset_init got=%b want=000000000", {count, m, busy, done, wrap, cfg_err});
        end
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (count !== 4'd7 && n < 40) begin step(); n++; end
        checks++;
        if (count !== 4'd7) begin failures++; $display("FAIL reset_reach7 got=%0d want=7", count); end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({count, m, busy, done, wrap, cfg_err} !== 9'b0) begin
                failures++;
                $display("FAIL reset_midrun%0d got=%b want=000000000", i, {count, m, busy, done, wrap, cfg_err});
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || count !== 4'd0) begin
            failures++; $display("FAIL reset_idle busy=%b count=%0d want busy=0 count=0", busy, count);
        end
    endtask

    task automatic test_wrap_mode();
        logic [3:0] exp_cnt [0:7] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd2, 4'd3, 4'd4, 4'd5};
        setup(4'd2, 4'd5, 1'b1, 1'b0, 8'd2);
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL wrap_busy got=%b want=1", busy); end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (count !== exp_cnt[i] || wrap !== (i == 4) || done !== 1'b0) begin
                failures++;
                $display("FAIL wrap_seq%0d count=%0d wrap=%b done=%b want count=%0d wrap=%b done=0",
                         i, count, wrap, done, exp_cnt[i], (i == 4));
            end
        end
        step();
        checks++;
        if (count !== 4'd5 || done !== 1'b1 || busy !== 1'b0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL wrap_done count=%0d done=%b busy=%b wrap=%b want 5 1 0 0", count, done, busy, wrap);
        end
        step();
        checks++;
        if (count !== 4'd5 || done !== 1'b0) begin
            failures++; $display("FAIL wrap_after count=%0d done=%b want 5 0", count, done);
        end
    endtask

    task automatic test_bounce_mode();
        logic [3:0] exp_cnt [0:9] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
        logic       exp_m   [0:9] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        setup(4'd0, 4'd3, 1'b0, 1'b1, 8'd3);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (count !== exp_cnt[i] || m !== exp_m[i] || wrap !== (i == 4 || i == 7) || done !== 1'b0) begin
                failures++;
                $display("FAIL bounce_seq%0d count=%0d m=%b wrap=%b done=%b want count=%0d m=%b wrap=%b done=0",
                         i, count, m, wrap, done, exp_cnt[i], exp_m[i], (i == 4 || i == 7));
            end
        end
        step();
        checks++;
        if (count !== 4'd0 || done !== 1'b1 || busy !== 1'b0 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL bounce_done count=%0d done=%b busy=%b wrap=%b want 0 1 0 0", count, done, busy, wrap);
        end
    endtask

    task automatic test_full_range_pause_stop();
        setup(4'd0, 4'd15, 1'b1, 1'b0, 8'd0);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 26; i++) begin
            step();
            checks++;
            if (count !== 4'(i % 16) || wrap !== (i == 16) || done !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL full_seq%0d count=%0d wrap=%b done=%b busy=%b want count=%0d wrap=%b done=0 busy=1",
                         i, count, wrap, done, busy, i % 16, (i == 16));
            end
        end
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (count !== 4'd9 || wrap !== 1'b0) begin
                failures++; $display("FAIL pause_hold%0d count=%0d wrap=%b want 9 0", i, count, wrap);
            end
        end
        pause = 1'b0;
        for (int i = 10; i <= 12; i++) begin
            step();
            checks++;
            if (count !== 4'(i)) begin failures++; $display("FAIL pause_resume count=%0d want=%0d", count, i); end
        end
        stop = 1'b1; step(); stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || count !== 4'd12 || done !== 1'b0) begin
            failures++; $display("FAIL stop_run busy=%b count=%0d done=%b want 0 12 0", busy, count, done);
        end
        step();
        checks++;
        if (count !== 4'd12 || done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL stop_hold count=%0d done=%b busy=%b want 12 0 0", count, done, busy);
        end
    endtask

    task automatic test_single_point();
        logic exp_m [0:2] = '{0, 1, 0};
        setup(4'd6, 4'd6, 1'b1, 1'b1, 8'd4);
        start = 1'b1; step(); start = 1'b0;
        step();
        checks++;
        if (count !== 4'd6 || m !== 1'b1) begin
            failures++; $display("FAIL point_load count=%0d m=%b want 6 1", count, m);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (count !== 4'd6 || m !== exp_m[i] || wrap !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL point_hit%0d count=%0d m=%b wrap=%b done=%b want 6 %b 1 0",
                         i, count, m, wrap, done, exp_m[i]);
            end
        end
        step();
        checks++;
        if (count !== 4'd6 || done !== 1'b1 || busy !== 1'b0 || wrap !== 1'b0 || m !== 1'b0) begin
            failures++;
            $display("FAIL point_done count=%0d done=%b busy=%b wrap=%b m=%b want 6 1 0 0 0",
                     count, done, busy, wrap, m);
        end
    endtask

    task automatic test_collisions();
        setup(4'd9, 4'd3, 1'b1, 1'b0, 8'd1);
        start = 1'b1; step(); start = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || count !== 4'd6) begin
            failures++; $display("FAIL cfg_err_pulse err=%b busy=%b count=%0d want 1 0 6", cfg_err, busy, count);
        end
        step();
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL cfg_err_clear err=%b busy=%b want 0 0", cfg_err, busy);
        end
        // start and stop together in IDLE: start wins
        setup(4'd2, 4'd5, 1'b1, 1'b0, 8'd1);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL start_beats_stop busy=%b want 1", busy); end
        setup(4'd0, 4'd9, 1'b0, 1'b1, 8'd7);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            checks++;
            if (count !== 4'(i) || m !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL busy_ignore count=%0d m=%b done=%b want %0d 1 0", count, m, done, i);
            end
            step();
        end
        checks++;
        if (count !== 4'd5 || done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL latched_done count=%0d done=%b busy=%b want 5 1 0", count, done, busy);
        end
        setup(4'd2, 4'd5, 1'b1, 1'b0, 8'd1);
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step(); step();
        checks++;
        if (count !== 4'd5 || busy !== 1'b1) begin
            failures++; $display("FAIL pre_final count=%0d busy=%b want 5 1", count, busy);
        end
        stop = 1'b1; step(); stop = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd5 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL stop_beats_final done=%b busy=%b count=%0d wrap=%b want 0 0 5 0", done, busy, count, wrap);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd5) begin
            failures++; $display("FAIL stop_final_idle done=%b busy=%b count=%0d want 0 0 5", done, busy, count);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_mode();
        test_bounce_mode();
        test_full_range_pause_stop();
        test_single_point();
        test_collisions();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached without completing the sequence");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/updown_count_sequencer.md
Name: updown_count_sequencer

Overview:
- Controller that sequences the team's up/down counter datapath.
- Holds the count register internally and steps it between programmable low/high bounds, either wrapping or bouncing (ping-pong).
- Counts bound hits ("passes") and stops after a programmed number of passes.
- Start/stop/pause handshake with busy/done status; drives mode output m with the counter convention (m=1 up, m=0 down).

Parameters:
WIDTH, 4, count/bound width in bits
PASS_W, 8, width of pass-count config and internal pass counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  pulse; sampled only in IDLE
stop  in  1  abort; sampled in LOAD/RUN
pause  in  1  level; freezes RUN stepping while high
cfg_lo  in  WIDTH  lower bound
cfg_hi  in  WIDTH  upper bound
cfg_dir  in  1  initial direction, 1=up, 0=down
cfg_bounce  in  1  1=reverse at bound, 0=wrap to opposite bound
cfg_passes  in  PASS_W  bound hits before done; 0=run forever
count  out  WIDTH  current count
m  out  1  current direction, 1=up
busy  out  1  high in LOAD and RUN
done  out  1  one-cycle pulse on normal completion
wrap  out  1  one-cycle pulse on each non-final bound hit
cfg_err  out  1  one-cycle pulse when start is rejected because cfg_lo > cfg_hi

Behaviour:
- Reset (rst=1 at edge): state=IDLE; count=0, m=0, busy=0, done=0, wrap=0, cfg_err=0; pass counter=0. rst overrides every other input, including mid-run.
- States: IDLE, LOAD, RUN.
- IDLE:
  - start=1 with cfg_lo<=cfg_hi: latch all cfg_*, m<=cfg_dir, pass<=0, busy<=1, go to LOAD.
  - start=1 with cfg_lo>cfg_hi: cfg_err<=1 for one cycle; stay in IDLE.
  - count holds its last value.
- LOAD (one cycle): count<=latched lo if m=1, else latched hi; go to RUN.
- RUN, each edge with pause=0:
  - Bound hit: count==hi with m=1, or count==lo with m=0.
  - Not a bound: count<=count+1 if up, count-1 if down.
  - Bound hit, final (passes!=0 and pass+1==passes): count holds, done<=1, busy<=0, go to IDLE. wrap is not asserted.
  - Bound hit, non-final: pass<=pass+1 (saturates when passes=0), wrap<=1.
    - bounce=0: count<=opposite bound (lo if up, hi if down); m unchanged.
    - bounce=1: m<=~m; count steps one toward the new direction. If lo==hi, count stays.
- RUN with pause=1: count, m, pass hold; no pulses. Bound detection resumes on the first edge with pause=0.
- stop=1 in LOAD or RUN: go to IDLE, busy<=0, count/m hold, no done. stop beats a same-cycle final bound hit. stop in IDLE is ignored; start beats stop there.
- start while busy is ignored; latched config is unaffected by cfg_* changes while busy.
- Arithmetic: modulo 2^WIDTH. Steps never cross a bound, so no overflow occurs within [lo,hi]. lo=0, hi=2^WIDTH-1 gives full-range wrap.
- Latency: start edge E0 -> busy=1 after E0; count=start value after E1; first step after E2.
- done, wrap, cfg_err are registered pulses exactly one cycle wide and are never asserted together.

Test Plan:
1. rst=1 for 2 cycles mid-run at count=7 -> next cycle count=0, m=0, busy=0, done=wrap=cfg_err=0, state IDLE.
2. lo=2, hi=5, dir=1, bounce=0, passes=2, start -> count 2,3,4,5,2,3,4,5 then holds 5; wrap pulses once (5->2); done pulses one cycle as count holds 5; busy falls with done.
3. lo=0, hi=3, dir=0, bounce=1, passes=3 -> count 3,2,1,0,1,2,3,2,1,0 then holds 0; m goes 0->1 at first hit, 1->0 at second; two wrap pulses, then done.
4. lo=0, hi=15, dir=1, passes=0:
   - runs 0..15, 0..; wrap pulses at each 15->0 and never done.
   - pause high 3 cycles at count=9 -> count stays 9, then continues 10.
   - stop at count=12 -> busy=0, count holds 12, no done.
5. lo=6, hi=6, bounce=1, passes=4 -> count stays 6; m toggles 3 times; 3 wrap pulses, then done.
6. Rejections and collisions:
   - lo=9, hi=3, start -> cfg_err one cycle, busy stays 0.
   - start while busy -> ignored.
   - stop on the same edge as the final bound hit -> no done, IDLE.
